// File: rtl/dcache_core_tag_ctrl.sv
// Tag RAM controller for the dcache: lookup/hit compare, single-line tag updates, invalidate and flush sweeps.
// Lookup response 1 cycle after accept; requests refused while a sweep runs; flush writebacks stall on wb_accept_i.
// Reset is synchronous; with AUTO_INVAL set, the cache comes out of reset already sweeping.
module dcache_core_tag_ctrl #(
    parameter int INDEX_W    = 8,
    parameter int TAG_W      = 19,
    parameter int OFFSET_W   = 5,
    parameter bit AUTO_INVAL = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               lookup_valid_i,
    input  logic [31:0]        lookup_addr_i,
    output logic               lookup_accept_o,
    output logic               resp_valid_o,
    output logic               resp_hit_o,
    output logic               resp_dirty_o,
    output logic [31:0]        resp_victim_addr_o,
    input  logic               upd_valid_i,
    input  logic [31:0]        upd_addr_i,
    input  logic               upd_tag_valid_i,
    input  logic               upd_tag_dirty_i,
    output logic               upd_accept_o,
    input  logic               inval_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               wb_valid_o,
    output logic [31:0]        wb_addr_o,
    input  logic               wb_accept_i,
    output logic [INDEX_W-1:0] tag_addr0_o,
    input  logic [TAG_W+1:0]   tag_data0_i,
    output logic [INDEX_W-1:0] tag_addr1_o,
    output logic [TAG_W+1:0]   tag_data1_o,
    output logic               tag_wr1_o
);

    typedef enum logic [2:0] {
        IDLE,
        INVAL,
        FLUSH_RD,
        FLUSH_CHK,
        FLUSH_WB
    } state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [INDEX_W-1:0] lk_idx_q;
    logic [TAG_W-1:0]   lk_tag_q;
    logic [TAG_W-1:0]   wb_tag_q;
    logic               resp_vld_q;
    logic               done_q, done_d;
    logic               clear_adv;

    logic               entry_vld;
    logic               entry_dirty;
    logic [TAG_W-1:0]   entry_tag;
    logic               last_idx;
    logic               lookup_fire;
    logic               unused_addr_bits;

    assign entry_vld   = tag_data0_i[TAG_W+1];
    assign entry_dirty = tag_data0_i[TAG_W];
    assign entry_tag   = tag_data0_i[TAG_W-1:0];
    assign last_idx    = &idx_q;
    assign lookup_fire = lookup_valid_i && (state_q == IDLE);

    // Byte offset within a line never affects tag state.
    assign unused_addr_bits = ^{lookup_addr_i[OFFSET_W-1:0], upd_addr_i[OFFSET_W-1:0]};

    // Hit/dirty come straight off the RAM read port; the RAM is write-first,
    // so a same-cycle update to the looked-up index is already reflected here.
    assign resp_valid_o       = resp_vld_q;
    assign resp_hit_o         = resp_vld_q && entry_vld && (entry_tag == lk_tag_q);
    assign resp_dirty_o       = resp_vld_q && entry_vld && entry_dirty;
    assign resp_victim_addr_o = resp_vld_q ? {entry_tag, lk_idx_q, {OFFSET_W{1'b0}}} : '0;

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign wb_valid_o = (state_q == FLUSH_WB);
    assign wb_addr_o  = {wb_tag_q, idx_q, {OFFSET_W{1'b0}}};

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        done_d          = 1'b0;
        clear_adv       = 1'b0;
        lookup_accept_o = 1'b0;
        upd_accept_o    = 1'b0;
        tag_addr0_o     = idx_q;
        tag_addr1_o     = idx_q;
        tag_data1_o     = '0;
        tag_wr1_o       = 1'b0;

        case (state_q)
            IDLE: begin
                lookup_accept_o = 1'b1;
                upd_accept_o    = 1'b1;
                tag_addr0_o     = lookup_addr_i[OFFSET_W +: INDEX_W];
                tag_addr1_o     = upd_addr_i[OFFSET_W +: INDEX_W];
                tag_data1_o     = {upd_tag_valid_i, upd_tag_dirty_i, upd_addr_i[31 -: TAG_W]};
                tag_wr1_o       = upd_valid_i;
                if (inval_i) begin
                    state_d = INVAL;
                    idx_d   = '0;
                end else if (flush_i) begin
                    state_d = FLUSH_RD;
                    idx_d   = '0;
                end
            end
            INVAL: begin
                tag_wr1_o = 1'b1;
                idx_d     = idx_q + 1'b1;
                if (last_idx) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            FLUSH_RD:  state_d = FLUSH_CHK;
            FLUSH_CHK: begin
                if (entry_vld && entry_dirty) state_d = FLUSH_WB;
                else                          clear_adv = 1'b1;
            end
            FLUSH_WB:  clear_adv = wb_accept_i;
            default:   state_d = IDLE;
        endcase

        if (clear_adv) begin
            tag_wr1_o = 1'b1;
            idx_d     = idx_q + 1'b1;
            state_d   = last_idx ? IDLE : FLUSH_RD;
            done_d    = last_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (AUTO_INVAL) state_q <= INVAL;
            else            state_q <= IDLE;
            idx_q      <= '0;
            lk_idx_q   <= '0;
            lk_tag_q   <= '0;
            wb_tag_q   <= '0;
            resp_vld_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            resp_vld_q <= lookup_fire;
            if (lookup_fire) begin
                lk_idx_q <= lookup_addr_i[OFFSET_W +: INDEX_W];
                lk_tag_q <= lookup_addr_i[31 -: TAG_W];
            end
            if (state_q == FLUSH_CHK) wb_tag_q <= entry_tag;
        end
    end

endmodule

// File: tb/tb_dcache_core_tag_ctrl.sv
// Directed bench for dcache_core_tag_ctrl with a write-first 256 x 21 tag RAM model.
module tb_dcache_core_tag_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lookup_valid_i;
    logic [31:0] lookup_addr_i;
    logic        lookup_accept_o;
    logic        resp_valid_o;
    logic        resp_hit_o;
    logic        resp_dirty_o;
    logic [31:0] resp_victim_addr_o;
    logic        upd_valid_i;
    logic [31:0] upd_addr_i;
    logic        upd_tag_valid_i;
    logic        upd_tag_dirty_i;
    logic        upd_accept_o;
    logic        inval_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic        wb_valid_o;
    logic [31:0] wb_addr_o;
    logic        wb_accept_i;
    logic [7:0]  tag_addr0_o;
    logic [20:0] tag_data0_i;
    logic [7:0]  tag_addr1_o;
    logic [20:0] tag_data1_o;
    logic        tag_wr1_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] A3   = 32'h1234_4060;
    localparam logic [31:0] A255 = 32'hCAFE_1FE0;

    always #5 clk_i = ~clk_i;

    dcache_core_tag_ctrl dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .lookup_valid_i     (lookup_valid_i),
        .lookup_addr_i      (lookup_addr_i),
        .lookup_accept_o    (lookup_accept_o),
        .resp_valid_o       (resp_valid_o),
        .resp_hit_o         (resp_hit_o),
        .resp_dirty_o       (resp_dirty_o),
        .resp_victim_addr_o (resp_victim_addr_o),
        .upd_valid_i        (upd_valid_i),
        .upd_addr_i         (upd_addr_i),
        .upd_tag_valid_i    (upd_tag_valid_i),
        .upd_tag_dirty_i    (upd_tag_dirty_i),
        .upd_accept_o       (upd_accept_o),
        .inval_i            (inval_i),
        .flush_i            (flush_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .wb_valid_o         (wb_valid_o),
        .wb_addr_o          (wb_addr_o),
        .wb_accept_i        (wb_accept_i),
        .tag_addr0_o        (tag_addr0_o),
        .tag_data0_i        (tag_data0_i),
        .tag_addr1_o        (tag_addr1_o),
        .tag_data1_o        (tag_data1_o),
        .tag_wr1_o          (tag_wr1_o)
    );

    // Tag RAM: 1-cycle read, write-first on address collision.
    logic [20:0] mem [256];
    logic [20:0] rd_q;
    logic        fill_req;

    always @(posedge clk_i) begin
        if (fill_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 21'h180000;
        end else if (tag_wr1_o) begin
            mem[tag_addr1_o] <= tag_data1_o;
        end
        rd_q <= (tag_wr1_o && tag_addr1_o == tag_addr0_o) ? tag_data1_o : mem[tag_addr0_o];
    end
    assign tag_data0_i = rd_q;

    function automatic int count_nonzero();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != 21'h0) n++;
        return n;
    endfunction

    task automatic do_lookup(input logic [31:0] a, output logic acc, output logic v,
                             output logic h, output logic d, output logic [31:0] vic);
        @(posedge clk_i); #1;
        lookup_valid_i = 1'b1;
        lookup_addr_i  = a;
        #1 acc = lookup_accept_o;
        @(posedge clk_i); #1;
        lookup_valid_i = 1'b0;
        #1;
        v   = resp_valid_o;
        h   = resp_hit_o;
        d   = resp_dirty_o;
        vic = resp_victim_addr_o;
    endtask

    task automatic do_update(input logic [31:0] a, input logic v, input logic d,
                             output logic acc, output logic wr, output logic [7:0] wa,
                             output logic [20:0] wd);
        @(posedge clk_i); #1;
        upd_valid_i     = 1'b1;
        upd_addr_i      = a;
        upd_tag_valid_i = v;
        upd_tag_dirty_i = d;
        #1;
        acc = upd_accept_o;
        wr  = tag_wr1_o;
        wa  = tag_addr1_o;
        wd  = tag_data1_o;
        @(posedge clk_i); #1;
        upd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        int busy_cnt = 0, wr_cnt = 0;
        logic got = 1'b0;
        logic acc, v, h, d;
        logic [31:0] vic;
        @(posedge clk_i); #1 fill_req = 1'b0;
        @(posedge clk_i); #1;
        n_checks++;
        if ({resp_valid_o, done_o, wb_valid_o, busy_o, lookup_accept_o, upd_accept_o} !== 6'b000100) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv/done/wb/busy/la/ua=%b expected 000100",
                     {resp_valid_o, done_o, wb_valid_o, busy_o, lookup_accept_o, upd_accept_o});
        end
        rst_i = 1'b0;
        #1;
        for (int c = 0; c < 400; c++) begin
            if (done_o) begin got = 1'b1; break; end
            if (busy_o) busy_cnt++;
            if (tag_wr1_o && tag_data1_o == 21'h0) wr_cnt++;
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL inval_done: done_o not seen within 400 cycles"); end
        n_checks++;
        if (busy_cnt !== 256) begin n_fail++; $display("FAIL inval_busy_cycles: got %0d expected 256", busy_cnt); end
        n_checks++;
        if (wr_cnt !== 256) begin n_fail++; $display("FAIL inval_zero_writes: got %0d expected 256", wr_cnt); end
        n_checks++;
        if (count_nonzero() !== 0) begin n_fail++; $display("FAIL inval_ram_clear: %0d nonzero entries, expected 0", count_nonzero()); end
        @(posedge clk_i); #1;
        n_checks++;
        if ({done_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL done_pulse_width: done/busy=%b expected 00", {done_o, busy_o}); end
        do_lookup(32'h0000_1020, acc, v, h, d, vic);
        n_checks++;
        if ({acc, v, h} !== 3'b110) begin n_fail++; $display("FAIL lookup_after_inval: acc/valid/hit=%b expected 110", {acc, v, h}); end
    endtask

    task automatic test_update_lookup();
        logic acc, wr, v, h, d;
        logic [7:0] wa;
        logic [20:0] wd;
        logic [31:0] vic;
        do_update(32'h8000_2040, 1'b1, 1'b0, acc, wr, wa, wd);
        n_checks++;
        if ({acc, wr, wa, wd} !== {1'b1, 1'b1, 8'h02, 21'h140001}) begin
            n_fail++;
            $display("FAIL update_write: acc=%b wr=%b idx=%h data=%h expected 1 1 02 140001", acc, wr, wa, wd);
        end
        do_lookup(32'h8000_2044, acc, v, h, d, vic);
        n_checks++;
        if ({v, h, d} !== 3'b110) begin n_fail++; $display("FAIL lookup_hit: valid/hit/dirty=%b expected 110", {v, h, d}); end
        do_lookup(32'h9000_2040, acc, v, h, d, vic);
        n_checks++;
        if ({v, h, d} !== 3'b100) begin n_fail++; $display("FAIL lookup_miss: valid/hit/dirty=%b expected 100", {v, h, d}); end
        n_checks++;
        if (vic !== 32'h8000_2040) begin n_fail++; $display("FAIL miss_victim: got %h expected 80002040", vic); end
    endtask

    task automatic test_same_cycle();
        @(posedge clk_i); #1;
        lookup_valid_i  = 1'b1;
        lookup_addr_i   = 32'hA000_2048;
        upd_valid_i     = 1'b1;
        upd_addr_i      = 32'hA000_2040;
        upd_tag_valid_i = 1'b1;
        upd_tag_dirty_i = 1'b1;
        @(posedge clk_i); #1;
        lookup_valid_i = 1'b0;
        upd_valid_i    = 1'b0;
        #1;
        n_checks++;
        if ({resp_valid_o, resp_hit_o, resp_dirty_o} !== 3'b111 || resp_victim_addr_o !== 32'hA000_2040) begin
            n_fail++;
            $display("FAIL write_first: valid/hit/dirty=%b victim=%h expected 111 a0002040",
                     {resp_valid_o, resp_hit_o, resp_dirty_o}, resp_victim_addr_o);
        end
        @(posedge clk_i); #1;
        n_checks++;
        if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL resp_single_cycle: resp_valid_o=%b expected 0", resp_valid_o); end
    endtask

    task automatic test_sweep_priority();
        logic acc, wr;
        logic [7:0] wa;
        logic [20:0] wd;
        int busy_cnt = 0, wb_seen = 0;
        logic got = 1'b0;
        do_update(A3, 1'b1, 1'b1, acc, wr, wa, wd);
        @(posedge clk_i); #1;
        inval_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        inval_i = 1'b0;
        flush_i = 1'b0;
        #1;
        for (int c = 0; c < 400; c++) begin
            if (done_o) begin got = 1'b1; break; end
            if (busy_o) busy_cnt++;
            if (wb_valid_o) wb_seen++;
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (!got || busy_cnt !== 256 || wb_seen !== 0) begin
            n_fail++;
            $display("FAIL inval_priority: done=%b busy=%0d wb=%0d expected 1 256 0", got, busy_cnt, wb_seen);
        end
        n_checks++;
        if (mem[3] !== 21'h0) begin n_fail++; $display("FAIL inval_priority_clear: mem[3]=%h expected 0", mem[3]); end
    endtask

    task automatic test_flush();
        logic acc, wr;
        logic [7:0] wa;
        logic [20:0] wd;
        logic [31:0] wb_addrs [2];
        int wb_cnt = 0, wait_cnt = 0;
        int stable_viol = 0, wr_viol = 0, lk_viol = 0, acc_viol = 0;
        logic in_wb = 1'b0, got = 1'b0;
        do_update(A3, 1'b1, 1'b1, acc, wr, wa, wd);
        do_update(A255, 1'b1, 1'b1, acc, wr, wa, wd);
        do_update(32'h0000_00A0, 1'b0, 1'b1, acc, wr, wa, wd);
        do_update(32'h5555_0200, 1'b1, 1'b0, acc, wr, wa, wd);
        wb_addrs[0] = '0;
        wb_addrs[1] = '0;
        @(posedge clk_i); #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i        = 1'b0;
        lookup_valid_i = 1'b1;
        lookup_addr_i  = 32'h0000_0000;
        #1;
        for (int c = 0; c < 3000; c++) begin
            if (done_o) begin got = 1'b1; break; end
            if (lookup_accept_o || upd_accept_o || resp_valid_o) lk_viol++;
            inval_i = (c == 20);
            if (wb_valid_o) begin
                if (!in_wb) begin
                    in_wb    = 1'b1;
                    wait_cnt = 0;
                    if (wb_cnt < 2) wb_addrs[wb_cnt] = wb_addr_o;
                    wb_cnt++;
                end
                if (wb_cnt == 1 && wait_cnt < 10) begin
                    if (wb_addr_o !== wb_addrs[0]) stable_viol++;
                    if (tag_wr1_o) wr_viol++;
                    wait_cnt++;
                end else begin
                    wb_accept_i = 1'b1;
                    #1;
                    if (!(tag_wr1_o && tag_data1_o == 21'h0 && tag_addr1_o == wb_addr_o[12:5])) acc_viol++;
                end
            end else begin
                in_wb = 1'b0;
            end
            @(posedge clk_i); #1;
            wb_accept_i = 1'b0;
            #1;
        end
        inval_i        = 1'b0;
        lookup_valid_i = 1'b0;
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL flush_done: done_o not seen within 3000 cycles"); end
        n_checks++;
        if (wb_cnt !== 2) begin n_fail++; $display("FAIL flush_wb_count: got %0d expected 2", wb_cnt); end
        n_checks++;
        if (wb_addrs[0] !== A3 || wb_addrs[1] !== A255) begin
            n_fail++;
            $display("FAIL flush_wb_addr: got %h %h expected %h %h", wb_addrs[0], wb_addrs[1], A3, A255);
        end
        n_checks++;
        if (stable_viol !== 0 || wr_viol !== 0) begin
            n_fail++;
            $display("FAIL wb_stall: addr changes=%0d tag writes=%0d expected 0 0", stable_viol, wr_viol);
        end
        n_checks++;
        if (lk_viol !== 0) begin n_fail++; $display("FAIL busy_blocks_requests: %0d accepting cycles, expected 0", lk_viol); end
        n_checks++;
        if (acc_viol !== 0) begin n_fail++; $display("FAIL wb_accept_clear: %0d bad clears, expected 0", acc_viol); end
        n_checks++;
        if (count_nonzero() !== 0) begin n_fail++; $display("FAIL flush_ram_clear: %0d nonzero entries, expected 0", count_nonzero()); end
    endtask

    task automatic test_reset_mid_flush();
        logic acc, wr;
        logic [7:0] wa;
        logic [20:0] wd;
        logic in_wb = 1'b0, got = 1'b0;
        do_update(A3, 1'b1, 1'b1, acc, wr, wa, wd);
        @(posedge clk_i); #1 flush_i = 1'b1;
        @(posedge clk_i); #1 flush_i = 1'b0;
        #1;
        for (int c = 0; c < 100; c++) begin
            if (wb_valid_o) begin in_wb = 1'b1; break; end
            @(posedge clk_i); #2;
        end
        n_checks++;
        if (!in_wb) begin n_fail++; $display("FAIL reach_flush_wb: wb_valid_o not seen within 100 cycles"); end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({wb_valid_o, busy_o, tag_wr1_o} !== 3'b011 || tag_addr1_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_abort: wb/busy/wr=%b idx=%h expected 011 00",
                     {wb_valid_o, busy_o, tag_wr1_o}, tag_addr1_o);
        end
        for (int c = 0; c < 400; c++) begin
            if (done_o) begin got = 1'b1; break; end
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (!got || mem[3] !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_reinval: done=%b mem[3]=%h expected 1 000000", got, mem[3]);
        end
    endtask

    initial begin
        rst_i           = 1'b1;
        fill_req        = 1'b1;
        lookup_valid_i  = 1'b0;
        lookup_addr_i   = '0;
        upd_valid_i     = 1'b0;
        upd_addr_i      = '0;
        upd_tag_valid_i = 1'b0;
        upd_tag_dirty_i = 1'b0;
        inval_i         = 1'b0;
        flush_i         = 1'b0;
        wb_accept_i     = 1'b0;
        test_reset();
        test_update_lookup();
        test_same_cycle();
        test_sweep_priority();
        test_flush();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
